// File: rtl/led_frame_composer.sv
// led_frame_composer
//   Takes a snapshot of the game state when frame_start is seen in IDLE.
//   Then streams one 24-bit {G,R,B} colour word per LED, index 0 up to
//   MAX_POS-1, over a valid/ready handshake to the strip serializer.
//   Every frame is built from its own snapshot, so game-state changes made
//   while the frame streams do not show until the next frame.
//
// Optional feature (compile-time macro COLOR_BLEND_EN):
//   defined   - on the game screen, players that share an LED are OR-blended.
//   undefined - on the game screen, one colour is shown, by priority
//               red > blue > green > yellow.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   frame_start           one-cycle request for a new frame (used only in IDLE)
//   current_screen        0 menu, 1 game, 2 end, 3 blank
//   *_cur_pos             player positions (PW bits each)
//   *_ready_to_play       menu ready flags
//   countdown             menu countdown value
//   pixel_ready           serializer accepts the current pixel
//   pixel_valid           pixel_data / pixel_index are valid
//   pixel_data            registered {G,R,B} colour word
//   pixel_index           LED index of the current pixel
//   pixel_last            high with pixel_valid on index MAX_POS-1
//   frame_busy            high while streaming and during the done cycle
//   frame_done            one-cycle pulse after the last pixel is accepted
module led_frame_composer #(
  parameter int         MAX_POS    = 16,
  parameter logic [7:0] BRIGHTNESS = 8'h20,
  localparam int        PW         = $clog2(MAX_POS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic [1:0]    current_screen,
  input  logic [PW-1:0] red_cur_pos,
  input  logic [PW-1:0] blue_cur_pos,
  input  logic [PW-1:0] green_cur_pos,
  input  logic [PW-1:0] yellow_cur_pos,
  input  logic          red_ready_to_play,
  input  logic          blue_ready_to_play,
  input  logic          green_ready_to_play,
  input  logic          yellow_ready_to_play,
  input  logic [2:0]    countdown,
  input  logic          pixel_ready,
  output logic          pixel_valid,
  output logic [23:0]   pixel_data,
  output logic [PW-1:0] pixel_index,
  output logic          pixel_last,
  output logic          frame_busy,
  output logic          frame_done
);

  localparam logic [23:0]   COL_RED    = {8'h00, BRIGHTNESS, 8'h00};
  localparam logic [23:0]   COL_BLUE   = {16'h0000, BRIGHTNESS};
  localparam logic [23:0]   COL_GREEN  = {BRIGHTNESS, 16'h0000};
  localparam logic [23:0]   COL_YELLOW = {BRIGHTNESS, BRIGHTNESS, 8'h00};
  localparam logic [23:0]   COL_WHITE  = {BRIGHTNESS, BRIGHTNESS, BRIGHTNESS};
  localparam logic [PW-1:0] LAST_IDX   = PW'(MAX_POS - 1);
  localparam logic [31:0]   MAX_POS_U  = 32'(MAX_POS);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t state, state_next;

  logic [1:0]    snap_screen;
  logic [PW-1:0] snap_red, snap_blue, snap_green, snap_yellow;
  logic [3:0]    snap_ready;
  logic [2:0]    snap_countdown;

  logic          capture, accept, is_last;
  logic [PW-1:0] idx_next;

  // Colour of LED idx for a given set of state values; rdy is {y,g,b,r}.
  function automatic logic [23:0] pixel_color(
    input logic [PW-1:0] idx,
    input logic [1:0]    scr,
    input logic [PW-1:0] pr, pb, pg, py,
    input logic [3:0]    rdy,
    input logic [2:0]    cd
  );
    logic [23:0] c;
    c = '0;
    case (scr)
      2'd0: begin
        if      (idx == PW'(0) && rdy[0]) c = COL_RED;
        else if (idx == PW'(1) && rdy[1]) c = COL_BLUE;
        else if (idx == PW'(2) && rdy[2]) c = COL_GREEN;
        else if (idx == PW'(3) && rdy[3]) c = COL_YELLOW;
        // i >= MAX_POS - c, rewritten as i + c >= MAX_POS so nothing underflows.
        // The countdown bar wins if it reaches down into the ready LEDs.
        if (cd != 3'd0 && (32'(idx) + 32'(cd) >= MAX_POS_U)) c = COL_WHITE;
      end
      2'd1: begin
`ifdef COLOR_BLEND_EN
        if (idx == pr) c = c | COL_RED;
        if (idx == pb) c = c | COL_BLUE;
        if (idx == pg) c = c | COL_GREEN;
        if (idx == py) c = c | COL_YELLOW;
`else
        if      (idx == pr) c = COL_RED;
        else if (idx == pb) c = COL_BLUE;
        else if (idx == pg) c = COL_GREEN;
        else if (idx == py) c = COL_YELLOW;
`endif
      end
      2'd2: begin
        if      (pr == LAST_IDX) c = COL_RED;
        else if (pb == LAST_IDX) c = COL_BLUE;
        else if (pg == LAST_IDX) c = COL_GREEN;
        else if (py == LAST_IDX) c = COL_YELLOW;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pixel_valid = 1'b0;
    frame_busy  = 1'b0;
    frame_done  = 1'b0;
    is_last     = (pixel_index == LAST_IDX);
    idx_next    = pixel_index + 1'b1;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        capture = frame_start;
        if (frame_start) state_next = STREAM;
      end
      STREAM: begin
        pixel_valid = 1'b1;
        frame_busy  = 1'b1;
        if (pixel_ready && is_last) state_next = DONE;
      end
      DONE: begin
        frame_busy = 1'b1;
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    accept     = pixel_valid && pixel_ready;
    pixel_last = pixel_valid && is_last;
  end

  // Pixel 0 is computed straight from the live inputs while they are being
  // captured, so it is ready in the first STREAM cycle. Each accepted pixel
  // preloads the next colour from the snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_screen    <= '0;
      snap_red       <= '0;
      snap_blue      <= '0;
      snap_green     <= '0;
      snap_yellow    <= '0;
      snap_ready     <= '0;
      snap_countdown <= '0;
      pixel_index    <= '0;
      pixel_data     <= '0;
    end else if (capture) begin
      snap_screen    <= current_screen;
      snap_red       <= red_cur_pos;
      snap_blue      <= blue_cur_pos;
      snap_green     <= green_cur_pos;
      snap_yellow    <= yellow_cur_pos;
      snap_ready     <= {yellow_ready_to_play, green_ready_to_play,
                         blue_ready_to_play, red_ready_to_play};
      snap_countdown <= countdown;
      pixel_index    <= '0;
      pixel_data     <= pixel_color('0, current_screen, red_cur_pos, blue_cur_pos,
                                    green_cur_pos, yellow_cur_pos,
                                    {yellow_ready_to_play, green_ready_to_play,
                                     blue_ready_to_play, red_ready_to_play},
                                    countdown);
    end else if (accept) begin
      if (is_last) begin
        pixel_index <= '0;
        pixel_data  <= '0;
      end else begin
        pixel_index <= idx_next;
        pixel_data  <= pixel_color(idx_next, snap_screen, snap_red, snap_blue,
                                   snap_green, snap_yellow, snap_ready,
                                   snap_countdown);
      end
    end
  end

endmodule

// File: doc/led_frame_composer.md
# led_frame_composer

Downstream consumer of the game domain unit. On each frame request it snapshots the four player positions, the ready flags, the menu countdown and the current screen, then streams one 24-bit GRB colour word per LED, index 0 to MAX_POS-1, over a valid/ready handshake to the LED strip serializer. Because of the snapshot, each frame is coherent even if game state changes while the frame is being streamed.

## Interface
Parameters:
- MAX_POS, 16, number of LEDs in the strip; must be at least 8. PW = $clog2(MAX_POS).
- BRIGHTNESS, 8'h20, channel value used for a lit colour component.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle request for a new frame
- current_screen  in  2  screen code: 0 = menu, 1 = game, 2 = end, 3 = blank
- red_cur_pos / blue_cur_pos / green_cur_pos / yellow_cur_pos  in  PW each  player positions
- red_ready_to_play / blue_ready_to_play / green_ready_to_play / yellow_ready_to_play  in  1 each  menu ready flags
- countdown  in  3  menu countdown value
- pixel_ready  in  1  serializer accepts the current pixel
- pixel_valid  out  1  pixel_data and pixel_index are valid
- pixel_data  out  24  colour word {G,R,B}
- pixel_index  out  PW  LED index of the current pixel
- pixel_last  out  1  high together with pixel_valid on index MAX_POS-1
- frame_busy  out  1  a frame is in progress
- frame_done  out  1  one-cycle pulse after the last pixel is accepted

## Operation
Colours, given as {G,R,B} with B = BRIGHTNESS:
- red = {0,B,0}
- blue = {0,0,B}
- green = {B,0,0}
- yellow = {B,B,0}
- white = {B,B,B}
- off = 0

FSM states: IDLE, STREAM, DONE.
- IDLE: frame_start=1 captures all inputs into snapshot registers and moves to STREAM with index 0. In any other state, frame_start is ignored.
- STREAM: pixel_valid=1. When pixel_valid and pixel_ready are both high, the pixel is accepted and the index increments. Accepting index MAX_POS-1 moves to DONE.
- DONE: frame_done=1 for one cycle, then IDLE.

Pixel colour for index i, computed from the snapshot:
- Screen 0 (menu):
  - i = 0..3 show the red/blue/green/yellow colour if that player is ready, else off.
  - If countdown = c > 0, LEDs MAX_POS-c to MAX_POS-1 are white.
  - All other LEDs are off.
- Screen 1 (game): a player's colour is shown where i equals that player's position. If no player is at i, the LED is off. Overlapping players: see Configuration.
- Screen 2 (end): every LED shows the winner's colour. The winner is the first player at position MAX_POS-1 in the priority red > blue > green > yellow. If no player is at that position, all LEDs are off.
- Screen 3: all LEDs off.

pixel_data is registered, and the value for index i must be valid in the same cycle pixel_valid is high for i.

## Timing
- Reset values: state IDLE, pixel_valid=0, pixel_data=0, pixel_index=0, pixel_last=0, frame_busy=0, frame_done=0, snapshot registers cleared.
- frame_start in cycle N gives pixel_valid=1 with index 0 in cycle N+1.
- While pixel_valid=1 and pixel_ready=0, pixel_data, pixel_index and pixel_last hold stable.
- With pixel_ready held high, there is one pixel per cycle. If the last pixel is accepted in cycle M, frame_done=1 in cycle M+1 and a new frame_start is accepted from cycle M+2.
- A frame is therefore at least MAX_POS+2 cycles from frame_start to the next accepted frame_start.
- frame_busy is high in STREAM and DONE.
- Input changes during a frame have no effect until the next snapshot.
- Reset asserted mid-frame: in the next cycle all outputs are at their reset values. No frame_done is issued.
- Reset and frame_start in the same cycle: reset wins and the request is dropped.

## Configuration
- COLOR_BLEND_EN defined:
  - In game screen, overlapping players blend per channel: bitwise OR of their colour words.
  - Example: red and green on the same LED give {B,B,0}.
- COLOR_BLEND_EN undefined:
  - The single highest-priority colour is shown, in the order red > blue > green > yellow.
- The macro has no effect on menu, end or blank screens.

## Test plan
- Game frame, MAX_POS=16, BRIGHTNESS=8'h20, red=3, blue=7, others=0, pixel_ready=1:
  - index 0 = 24'h200000 (green over yellow without blend; 24'h202000 with blend)
  - index 3 = 24'h002000
  - index 7 = 24'h000020
  - all other indices 0
  - frame_done exactly 17 cycles after frame_start
- Menu, red and yellow ready, countdown=3:
  - indices 0 and 3 carry red and yellow
  - indices 13..15 = 24'h202020
  - all others 0
- Backpressure: pixel_ready low for 5 cycles at index 4:
  - pixel_data and pixel_index hold for those 5 cycles
  - no pixel is skipped or duplicated
  - pixel_last only on index 15
- End screen, blue=15 and yellow=15:
  - all 16 pixels = 24'h000020 (blue wins by priority)
- Snapshot: red_cur_pos changes from 2 to 9 mid-frame:
  - frame still shows red at 2
  - next frame shows red at 9
- Reset asserted at index 6:
  - next cycle pixel_valid=0, frame_busy=0, no frame_done
  - a following frame_start restarts at index 0
